// File: rtl/georam_regs.sv
// georam_regs -- C64 bus-side register and decode stage for the GeoRAM SDRAM
// controller.
//
// Holds PAGE ($DFFE, 6 bits) and BLOCK ($DFFF, BLKBITS bits). Builds the
// 22-bit linear RAM address {BLOCK, PAGE, CA} for the $DE00-$DEFF window,
// drives the RAM strobes for the SDRAM controller, and steers RAM data or
// register readback onto the C64 data bus.
//
// Ports:
//   FCLK    fast clock, shared with the SDRAM controller
//   nRESET  asynchronous active-low C64 reset
//   PHI2    C64 PHI2
//   nIO1    /IO1 RAM window select; nIO2 /IO2 register page select
//   RnW     C64 R/W (1 = read)
//   CA/CD   C64 A[7:0] and data in
//   RDD     read data from the SDRAM controller
//   A       22-bit linear RAM address
//   RAMSEL  RAM access request; nWE RAM write strobe; WRD RAM write data
//   DOUT    data to the C64 bus; DOE C64 data bus output enable
module georam_regs #(
  parameter int BLKBITS  = 8,
  parameter bit READBACK = 1'b1
) (
  input  logic        FCLK,
  input  logic        nRESET,
  input  logic        PHI2,
  input  logic        nIO1,
  input  logic        nIO2,
  input  logic        RnW,
  input  logic [7:0]  CA,
  input  logic [7:0]  CD,
  input  logic [7:0]  RDD,
  output logic [21:0] A,
  output logic        RAMSEL,
  output logic        nWE,
  output logic [7:0]  WRD,
  output logic [7:0]  DOUT,
  output logic        DOE
);

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_e;

  state_e state_q, state_d;

  // Two-stage synchronisers; p3_q is the previous p2 used for fall detection.
  logic       p1_q, p2_q, p3_q;
  logic       io2_s1_q, io2_s2_q;
  logic       rnw_s1_q, rnw_s2_q;
  logic [7:0] ca_s1_q, ca_s2_q;

  logic [5:0]         page_q, page_d;
  logic [BLKBITS-1:0] block_q, block_d;
  logic [7:0]         cds_q, cds_d;
  logic               tgt_q, tgt_d;   // 0 = PAGE, 1 = BLOCK

  logic       phi2_fall;
  logic       reg_hit_s, reg_hit;
  logic [7:0] blk8;

  assign phi2_fall = p3_q & ~p2_q;
  assign reg_hit_s = (ca_s2_q[7:1] == 7'h7F);
  assign reg_hit   = (CA[7:1] == 7'h7F);

  always_comb begin
    blk8 = '0;
    blk8[BLKBITS-1:0] = block_q;
  end

  always_ff @(posedge FCLK or negedge nRESET) begin
    if (!nRESET) begin
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      p3_q     <= 1'b0;
      io2_s1_q <= 1'b0;
      io2_s2_q <= 1'b0;
      rnw_s1_q <= 1'b0;
      rnw_s2_q <= 1'b0;
      ca_s1_q  <= '0;
      ca_s2_q  <= '0;
      state_q  <= IDLE;
      page_q   <= '0;
      block_q  <= '0;
      cds_q    <= '0;
      tgt_q    <= 1'b0;
    end else begin
      p1_q     <= PHI2;
      p2_q     <= p1_q;
      p3_q     <= p2_q;
      io2_s1_q <= nIO2;
      io2_s2_q <= io2_s1_q;
      rnw_s1_q <= RnW;
      rnw_s2_q <= rnw_s1_q;
      ca_s1_q  <= CA;
      ca_s2_q  <= ca_s1_q;
      state_q  <= state_d;
      page_q   <= page_d;
      block_q  <= block_d;
      cds_q    <= cds_d;
      tgt_q    <= tgt_d;
    end
  end

  // The register write happens on the edge that leaves ARMED on PHI2Fall, so
  // the new value is visible 2-3 FCLK after the real PHI2 fall. COMMIT is a
  // one-cycle lockout; re-arming needs p2 high again, so at most one commit
  // lands per PHI2 cycle. PHI2Fall wins over the nIO2 release because both
  // pins go through identical synchronisers and /IO2 normally deasserts right
  // at the PHI2 fall.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    block_d = block_q;
    cds_d   = cds_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (p2_q && !io2_s2_q && !rnw_s2_q && reg_hit_s && nIO1) begin
          state_d = ARMED;
          tgt_d   = ca_s2_q[0];
        end
      end
      ARMED: begin
        if (p1_q) cds_d = CD;
        if (phi2_fall) begin
          state_d = COMMIT;
          if (tgt_q) block_d = cds_q[BLKBITS-1:0];
          else       page_d  = cds_q[5:0];
        end else if (io2_s2_q) begin
          state_d = IDLE;   // /IO2 glitch: drop without writing
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign A      = {blk8, page_q, CA};
  assign RAMSEL = ~nIO1;
  assign nWE    = RnW;
  assign WRD    = CD;
  assign DOE    = PHI2 & RnW & (~nIO1 | (READBACK & ~nIO2 & reg_hit));

  // RAM window has priority over the register page.
  always_comb begin
    DOUT = 8'h00;
    if (!nIO1)        DOUT = RDD;
    else if (reg_hit) DOUT = CA[0] ? blk8 : {2'b00, page_q};
  end

endmodule

// File: tb/tb_georam_regs.sv
// Bench for georam_regs: three instances share one C64 bus model
// (BLKBITS=8/READBACK=1, BLKBITS=5/READBACK=1, BLKBITS=5/READBACK=0) and
// are compared against a register-level model of PAGE/BLOCK.
module tb_georam_regs;
  logic       FCLK = 1'b0;
  logic       nRESET, PHI2, nIO1, nIO2, RnW;
  logic [7:0] CA, CD, RDD;

  logic [21:0] a8, a5, a0;
  logic        rs8, rs5, rs0, we8, we5, we0, doe8, doe5, doe0;
  logic [7:0]  wrd8, wrd5, wrd0, do8, do5, do0;

  int checks = 0;
  int errors = 0;

  logic [5:0] m_page;
  logic [7:0] m_blk8;
  logic [4:0] m_blk5;

  always #19 FCLK = ~FCLK;

  georam_regs #(.BLKBITS(8), .READBACK(1'b1)) u_d8 (
    .FCLK(FCLK), .nRESET(nRESET), .PHI2(PHI2), .nIO1(nIO1), .nIO2(nIO2),
    .RnW(RnW), .CA(CA), .CD(CD), .RDD(RDD), .A(a8), .RAMSEL(rs8), .nWE(we8),
    .WRD(wrd8), .DOUT(do8), .DOE(doe8));
  georam_regs #(.BLKBITS(5), .READBACK(1'b1)) u_d5 (
    .FCLK(FCLK), .nRESET(nRESET), .PHI2(PHI2), .nIO1(nIO1), .nIO2(nIO2),
    .RnW(RnW), .CA(CA), .CD(CD), .RDD(RDD), .A(a5), .RAMSEL(rs5), .nWE(we5),
    .WRD(wrd5), .DOUT(do5), .DOE(doe5));
  georam_regs #(.BLKBITS(5), .READBACK(1'b0)) u_d0 (
    .FCLK(FCLK), .nRESET(nRESET), .PHI2(PHI2), .nIO1(nIO1), .nIO2(nIO2),
    .RnW(RnW), .CA(CA), .CD(CD), .RDD(RDD), .A(a0), .RAMSEL(rs0), .nWE(we0),
    .WRD(wrd0), .DOUT(do0), .DOE(doe0));

  // ---- reference model: a CPU write lands if it is a clean /IO2 write to FE/FF
  task automatic model_reset();
    m_page = '0; m_blk8 = '0; m_blk5 = '0;
  endtask

  task automatic model_write(input logic rnw, input logic io1n, input logic io2n,
                             input logic [7:0] ca, input logic [7:0] cd);
    if (!rnw && io1n && !io2n && (ca == 8'hFE)) m_page = cd[5:0];
    if (!rnw && io1n && !io2n && (ca == 8'hFF)) begin
      m_blk8 = cd;
      m_blk5 = cd[4:0];
    end
  endtask

  // ---- bus cycle pieces: ~13 FCLK high, ~13 FCLK low
  task automatic bus_rise(input logic rnw, input logic io1n, input logic io2n,
                          input logic [7:0] ca, input logic [7:0] cd);
    @(negedge FCLK);
    CA = ca; RnW = rnw; nIO1 = io1n; nIO2 = io2n; CD = cd; RDD = 8'($urandom);
    @(negedge FCLK);
    PHI2 = 1'b1;
    repeat (7) @(negedge FCLK);
    #1;
  endtask

  // late_en changes CD one FCLK before the fall; rst_en asserts reset there.
  task automatic bus_fall(input logic [7:0] late_cd, input bit late_en, input bit rst_en);
    repeat (5) @(negedge FCLK);
    if (late_en) CD = late_cd;
    if (rst_en) nRESET = 1'b0;
    @(negedge FCLK);
    PHI2 = 1'b0;
    repeat (3) @(negedge FCLK);
    #1;
  endtask

  task automatic bus_tail();
    nRESET = 1'b1; nIO1 = 1'b1; nIO2 = 1'b1; RnW = 1'b1;
    repeat (10) @(negedge FCLK);
    #1;
  endtask

  task automatic test_reset();
    nRESET = 1'b0; PHI2 = 1'b0; nIO1 = 1'b1; nIO2 = 1'b1; RnW = 1'b1;
    CA = 8'h5A; CD = 8'h00; RDD = 8'h00;
    repeat (3) @(negedge FCLK);
    #1;
    checks++; if (a8 !== 22'h00005A) begin errors++; $display("FAIL reset_a8 got %h want %h", a8, 22'h00005A); end
    checks++; if (a5 !== 22'h00005A) begin errors++; $display("FAIL reset_a5 got %h want %h", a5, 22'h00005A); end
    checks++; if (doe8 !== 1'b0) begin errors++; $display("FAIL reset_doe got %b want 0", doe8); end
    checks++; if (rs8 !== 1'b0) begin errors++; $display("FAIL reset_ramsel got %b want 0", rs8); end
    nRESET = 1'b1;
    model_reset();
    bus_rise(1'b1, 1'b0, 1'b1, 8'h34, 8'h00);
    checks++; if (a8 !== 22'h000034) begin errors++; $display("FAIL ram_read_a got %h want %h", a8, 22'h000034); end
    checks++; if (rs8 !== 1'b1) begin errors++; $display("FAIL ram_read_ramsel got %b want 1", rs8); end
    checks++; if (doe8 !== 1'b1) begin errors++; $display("FAIL ram_read_doe got %b want 1", doe8); end
    checks++; if (do8 !== RDD) begin errors++; $display("FAIL ram_read_dout got %h want %h", do8, RDD); end
    checks++; if (we8 !== 1'b1) begin errors++; $display("FAIL ram_read_nwe got %b want 1", we8); end
    bus_fall(8'h00, 1'b0, 1'b0);
    bus_tail();
  endtask

  task automatic test_write_regs();
    bus_rise(1'b0, 1'b1, 1'b0, 8'hFE, 8'hC5);
    checks++; if (we8 !== 1'b0 || wrd8 !== 8'hC5) begin errors++; $display("FAIL wr_strobe got nwe=%b wrd=%h want 0/c5", we8, wrd8); end
    checks++; if (doe8 !== 1'b0) begin errors++; $display("FAIL wr_doe got %b want 0", doe8); end
    bus_fall(8'h00, 1'b0, 1'b0);
    model_write(1'b0, 1'b1, 1'b0, 8'hFE, 8'hC5);
    bus_tail();
    bus_rise(1'b0, 1'b1, 1'b0, 8'hFF, 8'h81);
    bus_fall(8'h00, 1'b0, 1'b0);   // now 3 FCLK after the fall
    model_write(1'b0, 1'b1, 1'b0, 8'hFF, 8'h81);
    CA = 8'h10; nIO1 = 1'b0; #1;
    checks++; if (a8 !== {m_blk8, m_page, 8'h10}) begin errors++; $display("FAIL addr8_after_commit got %h want %h", a8, {m_blk8, m_page, 8'h10}); end
    checks++; if (a5 !== {3'b000, m_blk5, m_page, 8'h10}) begin errors++; $display("FAIL addr5_after_commit got %h want %h", a5, {3'b000, m_blk5, m_page, 8'h10}); end
    bus_tail();
    bus_rise(1'b1, 1'b1, 1'b0, 8'hFE, 8'h00);
    checks++; if (do8 !== {2'b00, m_page} || doe8 !== 1'b1) begin errors++; $display("FAIL page_readback got %h/%b want %h/1", do8, doe8, {2'b00, m_page}); end
    bus_fall(8'h00, 1'b0, 1'b0);
    bus_tail();
  endtask

  task automatic test_blkbits();
    bus_rise(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
    bus_fall(8'h00, 1'b0, 1'b0);
    model_write(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
    bus_tail();
    bus_rise(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    checks++; if (do5 !== {3'b000, m_blk5} || doe5 !== 1'b1) begin errors++; $display("FAIL blk5_readback got %h/%b want %h/1", do5, doe5, {3'b000, m_blk5}); end
    checks++; if (doe0 !== 1'b0) begin errors++; $display("FAIL blk5_noreadback_doe got %b want 0", doe0); end
    checks++; if (do8 !== m_blk8 || doe8 !== 1'b1) begin errors++; $display("FAIL blk8_readback got %h/%b want %h/1", do8, doe8, m_blk8); end
    bus_fall(8'h00, 1'b0, 1'b0);
    bus_tail();
  endtask

  task automatic test_glitch_and_late_cd();
    bus_rise(1'b0, 1'b1, 1'b1, 8'hFE, 8'h3F);
    nIO2 = 1'b0;
    repeat (2) @(negedge FCLK);
    nIO2 = 1'b1;
    bus_fall(8'h00, 1'b0, 1'b0);
    bus_tail();
    checks++; if (a8 !== {m_blk8, m_page, CA}) begin errors++; $display("FAIL glitch_reject got %h want %h", a8, {m_blk8, m_page, CA}); end
    bus_rise(1'b0, 1'b1, 1'b0, 8'hFE, 8'h15);
    bus_fall(8'h2A, 1'b1, 1'b0);
    model_write(1'b0, 1'b1, 1'b0, 8'hFE, 8'h2A);
    bus_tail();
    checks++; if (a8[13:8] !== m_page) begin errors++; $display("FAIL late_cd_page got %h want %h", a8[13:8], m_page); end
  endtask

  task automatic test_reset_armed();
    bus_rise(1'b0, 1'b1, 1'b0, 8'hFE, 8'h11);
    bus_fall(8'h00, 1'b0, 1'b0);
    model_write(1'b0, 1'b1, 1'b0, 8'hFE, 8'h11);
    bus_tail();
    checks++; if (a8[13:8] !== m_page) begin errors++; $display("FAIL preload_page got %h want %h", a8[13:8], m_page); end
    bus_rise(1'b0, 1'b1, 1'b0, 8'hFE, 8'h3C);
    bus_fall(8'h00, 1'b0, 1'b1);
    model_reset();
    checks++; if (a8 !== {14'h0, CA}) begin errors++; $display("FAIL in_reset_a got %h want %h", a8, {14'h0, CA}); end
    bus_tail();
    bus_tail();
    checks++; if (a8 !== {m_blk8, m_page, CA}) begin errors++; $display("FAIL no_commit_after_reset got %h want %h", a8, {m_blk8, m_page, CA}); end
    // A normal write still lands, so the write path came back idle.
    bus_rise(1'b0, 1'b1, 1'b0, 8'hFE, 8'h07);
    bus_fall(8'h00, 1'b0, 1'b0);
    model_write(1'b0, 1'b1, 1'b0, 8'hFE, 8'h07);
    bus_tail();
    checks++; if (a8[13:8] !== m_page) begin errors++; $display("FAIL write_after_reset got %h want %h", a8[13:8], m_page); end
  endtask

  task automatic test_both_low();
    bus_rise(1'b1, 1'b0, 1'b0, 8'hFE, 8'h00);
    checks++; if (do8 !== RDD || doe8 !== 1'b1) begin errors++; $display("FAIL both_low_read got %h/%b want %h/1", do8, doe8, RDD); end
    bus_fall(8'h00, 1'b0, 1'b0);
    bus_tail();
    bus_rise(1'b0, 1'b0, 1'b0, 8'hFE, 8'h33);
    bus_fall(8'h00, 1'b0, 1'b0);
    model_write(1'b0, 1'b0, 1'b0, 8'hFE, 8'h33);
    bus_tail();
    checks++; if (a8[13:8] !== m_page) begin errors++; $display("FAIL both_low_write got %h want %h", a8[13:8], m_page); end
  endtask

  task automatic test_random();
    logic rnw, io1n, io2n, e_doe8, e_doe0;
    logic [7:0] ca, cd, e_do8;
    for (int i = 0; i < 40; i++) begin
      rnw  = 1'($urandom);
      io1n = 1'($urandom);
      io2n = 1'($urandom);
      case ($urandom_range(3))
        0:       ca = 8'hFE;
        1:       ca = 8'hFF;
        default: ca = 8'($urandom);
      endcase
      cd = 8'($urandom);
      bus_rise(rnw, io1n, io2n, ca, cd);
      e_doe8 = rnw & (~io1n | (~io2n & (ca >= 8'hFE)));
      e_doe0 = rnw & ~io1n;
      e_do8  = !io1n ? RDD : ((ca == 8'hFE) ? {2'b00, m_page} : m_blk8);
      checks++; if (a8 !== {m_blk8, m_page, ca}) begin errors++; $display("FAIL rnd_a8 #%0d got %h want %h", i, a8, {m_blk8, m_page, ca}); end
      checks++; if (a5 !== {3'b000, m_blk5, m_page, ca}) begin errors++; $display("FAIL rnd_a5 #%0d got %h want %h", i, a5, {3'b000, m_blk5, m_page, ca}); end
      checks++; if (rs8 !== ~io1n || we8 !== rnw || wrd8 !== cd) begin errors++; $display("FAIL rnd_strobes #%0d got %b%b%h want %b%b%h", i, rs8, we8, wrd8, ~io1n, rnw, cd); end
      checks++; if (doe8 !== e_doe8) begin errors++; $display("FAIL rnd_doe8 #%0d got %b want %b", i, doe8, e_doe8); end
      checks++; if (doe0 !== e_doe0) begin errors++; $display("FAIL rnd_doe0 #%0d got %b want %b", i, doe0, e_doe0); end
      if (e_doe8) begin
        checks++; if (do8 !== e_do8) begin errors++; $display("FAIL rnd_dout8 #%0d got %h want %h", i, do8, e_do8); end
      end
      bus_fall(8'h00, 1'b0, 1'b0);
      model_write(rnw, io1n, io2n, ca, cd);
      bus_tail();
    end
  endtask

  initial begin
    test_reset();
    test_write_regs();
    test_blkbits();
    test_glitch_and_late_cd();
    test_reset_armed();
    test_both_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
